// File: rtl/allocator_pkg.sv
// rtl/allocator_pkg.sv - shared state encoding, defaults and result shift/saturate helper
package allocator_pkg;

    localparam int DEF_DATA_W  = 18;
    localparam int DEF_ACC_W   = 48;
    localparam int DEF_LANES   = 2;
    localparam int DEF_DEPTH_W = 10;
    localparam int DEF_LEN_W   = 13;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_ARMED = 3'd2;
    localparam logic [2:0] ST_ACCUM = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;
    localparam logic [2:0] ST_OUT   = 3'd5;

    localparam int SAT_W = 64;

    // Accumulator is widened to SAT_W so one helper serves any ACC_W/DATA_W pair.
    function automatic logic signed [SAT_W-1:0] shift_sat(
        input logic signed [SAT_W-1:0] acc,
        input logic [5:0]              sh,
        input int                      data_w
    );
        logic signed [SAT_W-1:0] shifted;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        shifted = acc >>> sh;
        hi      = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo      = -hi - 64'sd1;
        if (shifted > hi) begin
            return hi;
        end else if (shifted < lo) begin
            return lo;
        end
        return shifted;
    endfunction

endpackage

// File: rtl/allocator_multi_lane_if.sv
// rtl/allocator_multi_lane_if.sv - coefficient, activation and result stream bundle
interface allocator_multi_lane_if
    import allocator_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LANES  = DEF_LANES
);
    logic                      flt_valid;
    logic                      flt_ready;
    logic [LANES*DATA_W-1:0]   flt_data;
    logic                      act_valid;
    logic                      act_ready;
    logic [DATA_W-1:0]         act_data;
    logic                      res_valid;
    logic                      res_ready;
    logic [LANES*DATA_W-1:0]   res_data;

    modport master (
        output flt_valid, flt_data, act_valid, act_data, res_ready,
        input  flt_ready, act_ready, res_valid, res_data
    );

    modport slave (
        input  flt_valid, flt_data, act_valid, act_data, res_ready,
        output flt_ready, act_ready, res_valid, res_data
    );
endinterface

// File: rtl/allocator_multi_lane_coef_ram.sv
// rtl/allocator_multi_lane_coef_ram.sv - per-lane coefficient store, one write port, registered read
module coef_ram #(
    parameter int DATA_W  = 18,
    parameter int DEPTH_W = 10
) (
    input  logic               clk,
    input  logic               we,
    input  logic [DEPTH_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic [DEPTH_W-1:0] rd_addr,
    output logic [DATA_W-1:0]  rd_data
);
    logic [DATA_W-1:0] mem_q [2**DEPTH_W];
    logic [DATA_W-1:0] rd_q;

    // Write-first: a length-1 load writes and reads address 0 on the same edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_q <= (we && (wr_addr == rd_addr)) ? wr_data : mem_q[rd_addr];
    end

    assign rd_data = rd_q;
endmodule

// File: rtl/allocator_multi_lane.sv
// rtl/allocator_multi_lane.sv - multi-lane FIR window engine sharing one activation stream
module allocator_multi_lane
    import allocator_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int LANES   = DEF_LANES,
    parameter int DEPTH_W = DEF_DEPTH_W,
    parameter int LEN_W   = DEF_LEN_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_load,
    input  logic [LEN_W-1:0]        cfg_length,
    input  logic [LANES*DATA_W-1:0] cfg_bias,
    input  logic [5:0]              cfg_shift,
    output logic                    cfg_err,
    output logic [15:0]             win_count,
    allocator_multi_lane_if.slave   bus
);
    localparam int PROD_W = 2 * DATA_W;
    localparam logic [LEN_W:0] MAX_LEN = (LEN_W+1)'(1) << DEPTH_W;

    state_t                  state_q, state_d;
    logic [DEPTH_W-1:0]      tap_q, tap_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [LANES*DATA_W-1:0] bias_q, bias_d;
    logic [5:0]              shift_q, shift_d;
    logic                    cfg_err_q, cfg_err_d;
    logic [15:0]             win_q, win_d;
    logic                    res_valid_q, res_valid_d;
    logic [LANES*DATA_W-1:0] res_data_q, res_data_d;

    logic                    s1_vld_q, s1_first_q, s1_last_q, s2_last_q;
    logic signed [PROD_W-1:0] prod [LANES];
    logic signed [PROD_W-1:0] s1_prod_q [LANES];
    logic signed [ACC_W-1:0]  acc_q [LANES];
    logic signed [ACC_W-1:0]  acc_d [LANES];
    logic [DATA_W-1:0]        coef_rd [LANES];

    logic flt_hs, act_hs, res_hs, len_ok, tap_last;

    assign bus.flt_ready = (state_q == ST_LOAD);
    // A cfg_load in ARMED takes the cycle, so no activation may slip in beside it.
    assign bus.act_ready = ((state_q == ST_ARMED) && !cfg_load) || (state_q == ST_ACCUM);
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign cfg_err       = cfg_err_q;
    assign win_count     = win_q;

    assign flt_hs   = bus.flt_valid && bus.flt_ready;
    assign act_hs   = bus.act_valid && bus.act_ready;
    assign res_hs   = bus.res_valid && bus.res_ready;
    assign len_ok   = (cfg_length != '0) && ({1'b0, cfg_length} <= MAX_LEN);
    assign tap_last = (LEN_W'(tap_q) == (len_q - LEN_W'(1)));

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        coef_ram #(
            .DATA_W  (DATA_W),
            .DEPTH_W (DEPTH_W)
        ) u_coef_ram (
            .clk     (clk),
            .we      (flt_hs),
            .wr_addr (tap_q),
            .wr_data (bus.flt_data[l*DATA_W +: DATA_W]),
            .rd_addr (tap_d),
            .rd_data (coef_rd[l])
        );
    end

    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        len_d       = len_q;
        bias_d      = bias_q;
        shift_d     = shift_q;
        cfg_err_d   = 1'b0;
        win_d       = win_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        case (state_q)
            ST_IDLE, ST_ARMED: begin
                if (cfg_load) begin
                    if (len_ok) begin
                        len_d   = cfg_length;
                        bias_d  = cfg_bias;
                        shift_d = cfg_shift;
                        tap_d   = '0;
                        state_d = ST_LOAD;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end else if (act_hs) begin
                    tap_d   = tap_last ? '0 : tap_q + DEPTH_W'(1);
                    state_d = tap_last ? ST_DRAIN : ST_ACCUM;
                end
            end
            ST_LOAD: begin
                if (flt_hs) begin
                    tap_d   = tap_last ? '0 : tap_q + DEPTH_W'(1);
                    state_d = tap_last ? ST_ARMED : ST_LOAD;
                end
            end
            ST_ACCUM: begin
                if (act_hs) begin
                    tap_d   = tap_last ? '0 : tap_q + DEPTH_W'(1);
                    state_d = tap_last ? ST_DRAIN : ST_ACCUM;
                end
            end
            ST_DRAIN: begin
                if (s2_last_q) begin
                    for (int l = 0; l < LANES; l++) begin
                        res_data_d[l*DATA_W +: DATA_W] =
                            DATA_W'(shift_sat(SAT_W'(acc_q[l]), shift_q, DATA_W));
                    end
                    res_valid_d = 1'b1;
                    state_d     = ST_OUT;
                end
            end
            ST_OUT: begin
                if (res_hs) begin
                    res_valid_d = 1'b0;
                    win_d       = win_q + 16'd1;
                    state_d     = ST_ARMED;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stage 1 holds the product of the accepted beat; stage 2 folds it into the accumulator.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            prod[l]  = PROD_W'($signed(bus.act_data)) * PROD_W'($signed(coef_rd[l]));
            acc_d[l] = acc_q[l];
            if (s1_vld_q) begin
                if (s1_first_q) begin
                    acc_d[l] = ACC_W'($signed(bias_q[l*DATA_W +: DATA_W])) + ACC_W'(s1_prod_q[l]);
                end else begin
                    acc_d[l] = acc_q[l] + ACC_W'(s1_prod_q[l]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            tap_q       <= '0;
            len_q       <= '0;
            bias_q      <= '0;
            shift_q     <= '0;
            cfg_err_q   <= 1'b0;
            win_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            s1_vld_q    <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s2_last_q   <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                s1_prod_q[l] <= '0;
                acc_q[l]     <= '0;
            end
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            len_q       <= len_d;
            bias_q      <= bias_d;
            shift_q     <= shift_d;
            cfg_err_q   <= cfg_err_d;
            win_q       <= win_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            s1_vld_q    <= act_hs;
            s1_first_q  <= act_hs && (state_q == ST_ARMED);
            s1_last_q   <= act_hs && tap_last;
            s2_last_q   <= s1_vld_q && s1_last_q;
            for (int l = 0; l < LANES; l++) begin
                s1_prod_q[l] <= prod[l];
                acc_q[l]     <= acc_d[l];
            end
        end
    end
endmodule

// File: tb/tb_allocator_multi_lane.sv
// tb/tb_allocator_multi_lane.sv - scoreboard bench for allocator_multi_lane
module tb_allocator_multi_lane;
    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_load;
    logic [12:0] cfg_length;
    logic [35:0] cfg_bias;
    logic [5:0]  cfg_shift;
    logic        cfg_err;
    logic [15:0] win_count;

    allocator_multi_lane_if #(.DATA_W(18), .LANES(2)) bus ();

    allocator_multi_lane #(
        .DATA_W (18), .ACC_W (48), .LANES (2), .DEPTH_W (10), .LEN_W (13)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_load   (cfg_load),
        .cfg_length (cfg_length),
        .cfg_bias   (cfg_bias),
        .cfg_shift  (cfg_shift),
        .cfg_err    (cfg_err),
        .win_count  (win_count),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          coef [2][8];
    int          bias [2];
    int          shift_v;
    int          len_v;
    int          act_v [8];
    int          exp_win;
    logic [35:0] exp_q [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [35:0] model();
        logic [35:0] r;
        longint      s;
        r = '0;
        for (int l = 0; l < 2; l++) begin
            s = longint'(bias[l]);
            for (int k = 0; k < len_v; k++) begin
                s += longint'(act_v[k]) * longint'(coef[l][k]);
            end
            s = s >>> shift_v;
            if (s > 131071) s = 131071;
            else if (s < -131072) s = -131072;
            r[l*18 +: 18] = s[17:0];
        end
        return r;
    endfunction

    task automatic do_cfg(input int l, input int b0, input int b1, input int sh);
        cfg_length = 13'(l);
        cfg_bias   = {18'(b1), 18'(b0)};
        cfg_shift  = 6'(sh);
        cfg_load   = 1'b1;
        @(posedge clk); #1;
        cfg_load = 1'b0;
        len_v = l; bias[0] = b0; bias[1] = b1; shift_v = sh;
    endtask

    task automatic load_coefs();
        int t;
        for (int k = 0; k < len_v; k++) begin
            bus.flt_valid = 1'b1;
            bus.flt_data  = {18'(coef[1][k]), 18'(coef[0][k])};
            t = 0;
            @(negedge clk);
            while (!bus.flt_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            chk("flt_handshake", 64'(bus.flt_ready), 64'd1);
            @(posedge clk); #1;
        end
        bus.flt_valid = 1'b0;
    endtask

    task automatic send_act(input int a, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
        end
        bus.act_valid = 1'b1;
        bus.act_data  = 18'(a);
        t = 0;
        @(negedge clk);
        while (!bus.act_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("act_handshake", 64'(bus.act_ready), 64'd1);
        @(posedge clk); #1;
        bus.act_valid = 1'b0;
    endtask

    task automatic bad_cfg(input int l);
        cfg_length = 13'(l);
        cfg_bias   = 36'h1_2345_6789;
        cfg_shift  = 6'd3;
        cfg_load   = 1'b1;
        @(posedge clk); #1;
        cfg_load = 1'b0;
        @(negedge clk);
        chk("cfg_err_pulse", 64'(cfg_err), 64'd1);
        @(negedge clk);
        chk("cfg_err_clear", 64'(cfg_err), 64'd0);
        chk("still_armed", 64'(bus.act_ready), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic run_window(input int bp, input bit ign);
        int          cnt;
        logic [35:0] got;
        exp_q.push_back(model());
        bus.res_ready = (bp == 0);
        for (int k = 0; k < len_v; k++) begin
            send_act(act_v[k], int'($urandom_range(0, 2)));
            if (k == 0 && ign && len_v > 1) begin
                cfg_length = 13'd2;
                cfg_load   = 1'b1;
                @(posedge clk); #1;
                cfg_load = 1'b0;
                @(negedge clk);
                chk("accum_cfg_ignored", 64'(cfg_err), 64'd0);
                @(posedge clk); #1;
            end
        end
        if (bp > 0) begin
            bus.act_valid = 1'b1;
            bus.act_data  = 18'd7;
        end
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!bus.res_valid && cnt < 20);
        chk("res_latency", 64'(cnt), 64'd3);
        got = bus.res_data;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk("bp_data_stable", 64'(bus.res_data), 64'(got));
            chk("bp_act_ready_low", 64'(bus.act_ready), 64'd0);
        end
        chk("res_data", 64'(bus.res_data), 64'(exp_q.pop_front()));
        bus.act_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        exp_win = (exp_win + 1) & 16'hffff;
        @(negedge clk);
        chk("res_valid_drop", 64'(bus.res_valid), 64'd0);
        chk("win_count", 64'(win_count), 64'(exp_win));
        @(posedge clk); #1;
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc_n, res_n, cyc;
        rst = 1'b0; cfg_load = 1'b0; cfg_length = '0; cfg_bias = '0; cfg_shift = '0;
        bus.flt_valid = 1'b0; bus.flt_data = '0;
        bus.act_valid = 1'b0; bus.act_data = '0; bus.res_ready = 1'b1;
        exp_win = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_cfg_err", 64'(cfg_err), 64'd0);
        chk("rst_flt_ready", 64'(bus.flt_ready), 64'd0);
        chk("rst_act_ready", 64'(bus.act_ready), 64'd0);
        chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
        chk("rst_res_data", 64'(bus.res_data), 64'd0);
        chk("rst_win_count", 64'(win_count), 64'd0);
        @(posedge clk); #1;

        // Basic three-tap window with gaps, then backpressure and coefficient reuse.
        coef[0][0] = 1;  coef[0][1] = 2; coef[0][2] = 3;
        coef[1][0] = -1; coef[1][1] = 0; coef[1][2] = 1;
        act_v[0] = 4; act_v[1] = 5; act_v[2] = 6;
        do_cfg(3, 10, 0, 0);
        load_coefs();
        run_window(0, 1'b0);
        run_window(5, 1'b0);

        bad_cfg(0);
        bad_cfg(1025);
        run_window(0, 1'b0);
        run_window(0, 1'b1);

        act_v[0] = -7; act_v[1] = 100; act_v[2] = -3;
        run_window(0, 1'b0);

        // Reset in the middle of a window.
        act_v[0] = 4; act_v[1] = 5; act_v[2] = 6;
        send_act(4, 0);
        send_act(5, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_cfg_err", 64'(cfg_err), 64'd0);
        chk("midrst_flt_ready", 64'(bus.flt_ready), 64'd0);
        chk("midrst_act_ready", 64'(bus.act_ready), 64'd0);
        chk("midrst_res_valid", 64'(bus.res_valid), 64'd0);
        chk("midrst_res_data", 64'(bus.res_data), 64'd0);
        chk("midrst_win_count", 64'(win_count), 64'd0);
        rst = 1'b1;
        exp_win = 0;
        bus.act_valid = 1'b1;
        bus.act_data  = 18'd9;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("idle_act_blocked", 64'(bus.act_ready), 64'd0);
        end
        @(posedge clk); #1;
        bus.act_valid = 1'b0;
        do_cfg(3, 10, 0, 0);
        load_coefs();
        run_window(0, 1'b0);

        // Length-1 windows at the saturation corners.
        coef[0][0] = 131071; coef[1][0] = -131072;
        act_v[0] = 131071;
        do_cfg(1, 0, 0, 0);
        load_coefs();
        run_window(0, 1'b0);
        do_cfg(1, 0, 0, 17);
        load_coefs();
        run_window(0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            act_v[0] = int'($urandom_range(0, 262143)) - 131072;
            run_window(0, 1'b0);
        end

        // 65536 back-to-back length-1 windows must bring win_count back around.
        acc_n = 0; res_n = 0; cyc = 0;
        bus.act_data  = 18'd1;
        bus.act_valid = 1'b1;
        bus.res_ready = 1'b1;
        while (res_n < 65536 && cyc < 300000) begin
            @(negedge clk);
            if (bus.act_valid && bus.act_ready) acc_n++;
            if (bus.res_valid && bus.res_ready) res_n++;
            @(posedge clk); #1;
            cyc++;
            if (acc_n == 65536) bus.act_valid = 1'b0;
        end
        exp_win = (exp_win + 65536) & 16'hffff;
        @(negedge clk);
        chk("wrap_results", 64'(res_n), 64'd65536);
        chk("wrap_win_count", 64'(win_count), 64'(exp_win));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
